// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals of the memory port arbiter.
// slave  : the arbiter side.
// master : the pipeline/memory model side.
interface mem_port_arbiter_if;
    // Fetch port
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;

    // Data (load/store) port
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;

    // Single-port memory side
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    // Status towards the pipeline
    logic        bus_err;
    logic        stall_F;
    logic        stall_M;

    modport slave (
        input  if_req, if_addr,
        output if_rdata, if_done,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        output d_rdata, d_done,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack,
        output bus_err, stall_F, stall_M
    );

    modport master (
        output if_req, if_addr,
        input  if_rdata, if_done,
        output d_req, d_we, d_be, d_addr, d_wdata,
        input  d_rdata, d_done,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_rdata, mem_ack,
        input  bus_err, stall_F, stall_M
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between the instruction fetch port
// and the load/store port. Data normally wins; a starvation counter forces a
// fetch grant after STARVE_LIMIT consecutive data grants with fetch pending.
// A BUSY transaction without mem_ack is aborted after TIMEOUT cycles and
// completes with bus_err and zero read data.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT      = 16,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);

    localparam int unsigned WAIT_W   = 8;
    localparam int unsigned STARVE_W = 4;
    localparam int unsigned DATA_W   = 32;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BUSY_I = 2'd1;
    localparam logic [1:0] S_BUSY_D = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [WAIT_W-1:0]   r_wait;
    logic [STARVE_W-1:0] r_starve;

    logic                r_mem_req;
    logic                r_mem_we;
    logic [3:0]          r_mem_be;
    logic [DATA_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;

    logic [DATA_W-1:0]   r_if_rdata;
    logic [DATA_W-1:0]   r_d_rdata;
    logic                r_if_done;
    logic                r_d_done;
    logic                r_bus_err;

    logic                w_busy;
    logic                w_grant_i;
    logic                w_grant_d;
    logic                w_ack;
    logic                w_timeout;
    logic                w_starve_ok;
    logic                w_finish;

    // Next-state logic and grant decision
    always_comb begin
        w_state_nxt = r_state;
        w_grant_i   = 1'b0;
        w_grant_d   = 1'b0;
        w_busy      = (r_state == S_BUSY_I) || (r_state == S_BUSY_D);
        w_ack       = w_busy && bus.mem_ack;
        w_timeout   = w_busy && !bus.mem_ack &&
                      (r_wait == WAIT_W'(TIMEOUT - 1));
        w_starve_ok = (r_starve < STARVE_W'(STARVE_LIMIT));
        w_finish    = w_ack || w_timeout;

        case (r_state)
            S_IDLE: begin
                if (bus.d_req && w_starve_ok) begin
                    w_grant_d   = 1'b1;
                    w_state_nxt = S_BUSY_D;
                end else if (bus.if_req) begin
                    w_grant_i   = 1'b1;
                    w_state_nxt = S_BUSY_I;
                end else if (bus.d_req) begin
                    w_grant_d   = 1'b1;
                    w_state_nxt = S_BUSY_D;
                end
            end
            S_BUSY_I, S_BUSY_D: begin
                if (w_finish) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // BUSY wait counter: restarts on every grant, saturates instead of wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait <= '0;
        end else if (w_grant_i || w_grant_d) begin
            r_wait <= '0;
        end else if (w_busy && (r_wait != '1)) begin
            r_wait <= r_wait + WAIT_W'(1);
        end
    end

    // Starvation counter: counts data grants that bypassed a pending fetch
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_grant_i || !bus.if_req) begin
                r_starve <= '0;
            end else if (w_grant_d && (r_starve != STARVE_W'(STARVE_LIMIT))) begin
                r_starve <= r_starve + STARVE_W'(1);
            end
        end
    end

    // Memory command: latched from the winner at grant, held until the next grant
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= 4'h0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_req <= (w_state_nxt == S_BUSY_I) || (w_state_nxt == S_BUSY_D);
            if (w_grant_d) begin
                r_mem_we    <= bus.d_we;
                r_mem_be    <= bus.d_be;
                r_mem_addr  <= bus.d_addr;
                r_mem_wdata <= bus.d_wdata;
            end else if (w_grant_i) begin
                r_mem_we    <= 1'b0;
                r_mem_be    <= 4'hF;
                r_mem_addr  <= bus.if_addr;
                r_mem_wdata <= '0;
            end
        end
    end

    // Completion: one-cycle done pulse in RESP, read data captured for the owner
    always_ff @(posedge clk) begin
        if (rst) begin
            r_if_done  <= 1'b0;
            r_d_done   <= 1'b0;
            r_bus_err  <= 1'b0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else begin
            r_if_done <= 1'b0;
            r_d_done  <= 1'b0;
            r_bus_err <= 1'b0;
            if (w_finish) begin
                r_bus_err <= w_timeout;
                if (r_state == S_BUSY_I) begin
                    r_if_done  <= 1'b1;
                    r_if_rdata <= w_ack ? bus.mem_rdata : '0;
                end else begin
                    r_d_done  <= 1'b1;
                    r_d_rdata <= w_ack ? bus.mem_rdata : '0;
                end
            end
        end
    end

    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_be    = r_mem_be;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.if_done   = r_if_done;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.d_done    = r_d_done;
    assign bus.bus_err   = r_bus_err;

    // Pipeline stalls drop in the same cycle the done pulse appears
    assign bus.stall_F = bus.if_req & ~r_if_done;
    assign bus.stall_M = bus.d_req  & ~r_d_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: reset check, a table of single
// transactions, hand-written arbitration/reset sequences and a randomized run
// against a transaction-timeline reference model.
module tb_mem_port_arbiter;

    localparam int unsigned TO = 16;
    localparam int unsigned SL = 4;

    logic clk;
    logic rst;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.TIMEOUT(TO), .STARVE_LIMIT(SL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: cycle budget expired", name);
    endtask

    typedef struct {
        logic        is_d;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          ack_dly;
        logic [31:0] mrdata;
        logic        exp_we;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        int          exp_lat;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t        vecs [7];
    logic [31:0] exp_ird;
    logic [31:0] exp_drd;

    // One isolated request; latency counted in cycles from request drive to done
    task automatic run_txn(input int idx, input vec_t v);
        bit seen;
        int busy;
        seen = 1'b0;
        busy = 0;
        bus.if_req  = !v.is_d;
        bus.d_req   = v.is_d;
        bus.if_addr = v.is_d ? 32'hDEAD_0000 : v.addr;
        bus.d_addr  = v.is_d ? v.addr : 32'hDEAD_0004;
        bus.d_we    = v.we;
        bus.d_be    = v.be;
        bus.d_wdata = v.wdata;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            if (bus.mem_req === 1'b1) begin
                check($sformatf("v%0d_addr", idx), bus.mem_addr, v.addr);
                check($sformatf("v%0d_we", idx), 32'(bus.mem_we), 32'(v.exp_we));
                check($sformatf("v%0d_be", idx), 32'(bus.mem_be), 32'(v.exp_be));
                check($sformatf("v%0d_wdata", idx), bus.mem_wdata, v.exp_wdata);
                check($sformatf("v%0d_stall_busy", idx),
                      32'(v.is_d ? bus.stall_M : bus.stall_F), 32'd1);
                if (busy == v.ack_dly) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = v.mrdata;
                end
                busy++;
            end
            if ((v.is_d ? bus.d_done : bus.if_done) === 1'b1) begin
                seen = 1'b1;
                check($sformatf("v%0d_latency", idx), 32'(k), 32'(v.exp_lat));
                check($sformatf("v%0d_bus_err", idx), 32'(bus.bus_err), 32'(v.exp_err));
                check($sformatf("v%0d_rdata", idx),
                      v.is_d ? bus.d_rdata : bus.if_rdata, v.exp_rdata);
                check($sformatf("v%0d_other_rdata_hold", idx),
                      v.is_d ? bus.if_rdata : bus.d_rdata, v.is_d ? exp_ird : exp_drd);
                check($sformatf("v%0d_mem_req_resp", idx), 32'(bus.mem_req), 32'd0);
                check($sformatf("v%0d_stall_resp", idx),
                      32'(v.is_d ? bus.stall_M : bus.stall_F), 32'd0);
                if (v.is_d) exp_drd = v.exp_rdata;
                else        exp_ird = v.exp_rdata;
                bus.if_req = 1'b0;
                bus.d_req  = 1'b0;
            end
        end
        if (!seen) bound_fail($sformatf("v%0d_done_seen", idx));
        bus.if_req  = 1'b0;
        bus.d_req   = 1'b0;
        bus.mem_ack = 1'b0;
        @(negedge clk);
    endtask

    // Wait for a grant, ack it on its first BUSY cycle, report which port completed
    task automatic serve(input logic [31:0] rd, output int owner, output logic [31:0] addr,
                         output logic we, output logic [3:0] be, output logic [31:0] wdata);
        owner = 2;
        addr  = '0;
        we    = 1'b0;
        be    = 4'h0;
        wdata = '0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.mem_req === 1'b1) break;
        end
        if (bus.mem_req !== 1'b1) begin
            bound_fail("serve_grant");
            return;
        end
        addr          = bus.mem_addr;
        we            = bus.mem_we;
        be            = bus.mem_be;
        wdata         = bus.mem_wdata;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rd;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        if (bus.d_done === 1'b1)       owner = 1;
        else if (bus.if_done === 1'b1) owner = 0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_mem_req"},   32'(bus.mem_req), 32'd0);
        check({tag, "_if_done"},   32'(bus.if_done), 32'd0);
        check({tag, "_d_done"},    32'(bus.d_done), 32'd0);
        check({tag, "_bus_err"},   32'(bus.bus_err), 32'd0);
        check({tag, "_if_rdata"},  bus.if_rdata, 32'd0);
        check({tag, "_d_rdata"},   bus.d_rdata, 32'd0);
        check({tag, "_mem_addr"},  bus.mem_addr, 32'd0);
        check({tag, "_mem_we"},    32'(bus.mem_we), 32'd0);
        check({tag, "_mem_be"},    32'(bus.mem_be), 32'd0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
    endtask

    // Random-phase reference model state
    int          m_next_idle;
    bit          m_txn;
    int          m_g;
    int          m_len;
    int          m_ack_dly;
    bit          m_d;
    bit          m_err;
    int          m_starve;
    int          m_r;
    logic [31:0] m_rd;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_we;
    logic [3:0]  e_be;
    logic [31:0] e_ird;
    logic [31:0] e_drd;
    bit          x_req;
    bit          x_idone;
    bit          x_ddone;

    int          own;
    logic [31:0] s_addr;
    logic        s_we;
    logic [3:0]  s_be;
    logic [31:0] s_wdata;
    int          busy_seen;

    initial begin
        rst           = 1'b1;
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_be      = 4'h0;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.mem_rdata = '0;
        bus.mem_ack   = 1'b0;
        exp_ird       = '0;
        exp_drd       = '0;

        //            is_d we    be     addr          wdata         dly mrdata        e_we e_be  e_wdata       lat e_err e_rdata
        vecs[0] = '{1'b0, 1'b1, 4'h2, 32'h0000_0100, 32'h55AA_55AA, 0,  32'h0000_0013, 1'b0, 4'hF, 32'h0,         2,  1'b0, 32'h0000_0013};
        vecs[1] = '{1'b1, 1'b0, 4'hF, 32'h0000_0040, 32'h1234_5678, 3,  32'hDEAD_BEEF, 1'b0, 4'hF, 32'h1234_5678, 5,  1'b0, 32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 1'b1, 4'h5, 32'h0000_0080, 32'hCAFE_F00D, 1,  32'h0000_0077, 1'b1, 4'h5, 32'hCAFE_F00D, 3,  1'b0, 32'h0000_0077};
        vecs[3] = '{1'b1, 1'b0, 4'hF, 32'h0000_0044, 32'h0,         99, 32'h0000_9999, 1'b0, 4'hF, 32'h0,         17, 1'b1, 32'h0};
        vecs[4] = '{1'b0, 1'b0, 4'h0, 32'h0000_0104, 32'h0,         15, 32'h0BAD_F00D, 1'b0, 4'hF, 32'h0,         17, 1'b0, 32'h0BAD_F00D};
        vecs[5] = '{1'b0, 1'b0, 4'h0, 32'h0000_0108, 32'h0,         16, 32'h0000_1111, 1'b0, 4'hF, 32'h0,         17, 1'b1, 32'h0};
        vecs[6] = '{1'b1, 1'b1, 4'h8, 32'hFFFF_FFFC, 32'h0102_0304, 0,  32'hFFFF_FFFF, 1'b1, 4'h8, 32'h0102_0304, 2,  1'b0, 32'hFFFF_FFFF};

        // Reset state
        repeat (3) @(negedge clk);
        check_quiet("reset");
        check("reset_stall_F", 32'(bus.stall_F), 32'd0);
        check("reset_stall_M", 32'(bus.stall_M), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Table of isolated transactions
        for (int i = 0; i < 7; i++) run_txn(i, vecs[i]);

        // Simultaneous requests: data first, then fetch
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_be    = 4'h3;
        bus.d_addr  = 32'h0000_2000;
        bus.d_wdata = 32'hAABB_CCDD;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0300;
        serve(32'h0000_00A1, own, s_addr, s_we, s_be, s_wdata);
        check("both_first_owner", 32'(own), 32'd1);
        check("both_first_addr", s_addr, 32'h0000_2000);
        check("both_first_we", 32'(s_we), 32'd1);
        check("both_first_be", 32'(s_be), 32'h3);
        check("both_first_wdata", s_wdata, 32'hAABB_CCDD);
        bus.d_req = 1'b0;
        serve(32'h0000_00B2, own, s_addr, s_we, s_be, s_wdata);
        check("both_second_owner", 32'(own), 32'd0);
        check("both_second_addr", s_addr, 32'h0000_0300);
        check("both_second_we", 32'(s_we), 32'd0);
        check("both_second_be", 32'(s_be), 32'hF);
        check("both_second_wdata", s_wdata, 32'h0);
        check("both_second_rdata", bus.if_rdata, 32'h0000_00B2);
        bus.if_req = 1'b0;
        repeat (2) @(negedge clk);

        // Starvation: back-to-back stores with a fetch pending
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_be    = 4'hF;
        bus.d_addr  = 32'h0000_3000;
        bus.d_wdata = 32'h0000_0001;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0400;
        for (int i = 0; i < 6; i++) begin
            serve(32'(i), own, s_addr, s_we, s_be, s_wdata);
            check($sformatf("starve_owner_%0d", i), 32'(own), (i == 4) ? 32'd0 : 32'd1);
            bus.d_addr  = 32'h0000_3004 + 32'(4 * i);
            bus.d_wdata = 32'(i + 2);
        end
        bus.d_req  = 1'b0;
        bus.if_req = 1'b0;
        repeat (2) @(negedge clk);

        // Reset on the third BUSY cycle, late ack afterwards
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h0000_0500;
        busy_seen  = 0;
        for (int k = 0; k < 20 && busy_seen < 3; k++) begin
            @(negedge clk);
            if (bus.mem_req === 1'b1) busy_seen++;
        end
        if (busy_seen < 3) bound_fail("rst_busy_reach");
        rst       = 1'b1;
        bus.d_req = 1'b0;
        @(negedge clk);
        check("rstbusy_mem_req", 32'(bus.mem_req), 32'd0);
        check("rstbusy_d_done", 32'(bus.d_done), 32'd0);
        rst           = 1'b0;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h0000_0BAD;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        check_quiet("rstack");
        @(negedge clk);
        check("rstack_late_d_done", 32'(bus.d_done), 32'd0);
        check("rstack_late_mem_req", 32'(bus.mem_req), 32'd0);

        // mem_ack pulses with no requests must change nothing
        for (int k = 0; k < 4; k++) begin
            bus.mem_ack   = 1'(k % 2 == 0);
            bus.mem_rdata = $urandom;
            @(negedge clk);
            check_quiet($sformatf("idle_ack%0d", k));
        end
        bus.mem_ack = 1'b0;

        // Randomized run against the timeline model
        m_next_idle = 0;
        m_txn       = 1'b0;
        m_g         = 0;
        m_len       = 0;
        m_ack_dly   = 0;
        m_d         = 1'b0;
        m_err       = 1'b0;
        m_starve    = 0;
        m_rd        = '0;
        e_addr      = '0;
        e_wdata     = '0;
        e_we        = 1'b0;
        e_be        = 4'h0;
        e_ird       = '0;
        e_drd       = '0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            x_req   = m_txn && (n >= m_g + 1) && (n <= m_g + m_len);
            x_idone = m_txn && (n == m_g + m_len + 1) && !m_d;
            x_ddone = m_txn && (n == m_g + m_len + 1) && m_d;
            if (x_idone) e_ird = m_err ? 32'h0 : m_rd;
            if (x_ddone) e_drd = m_err ? 32'h0 : m_rd;

            check("rnd_mem_req", 32'(bus.mem_req), 32'(x_req));
            check("rnd_if_done", 32'(bus.if_done), 32'(x_idone));
            check("rnd_d_done", 32'(bus.d_done), 32'(x_ddone));
            check("rnd_bus_err", 32'(bus.bus_err), 32'((x_idone || x_ddone) && m_err));
            check("rnd_if_rdata", bus.if_rdata, e_ird);
            check("rnd_d_rdata", bus.d_rdata, e_drd);
            check("rnd_mem_addr", bus.mem_addr, e_addr);
            check("rnd_mem_we", 32'(bus.mem_we), 32'(e_we));
            check("rnd_mem_be", 32'(bus.mem_be), 32'(e_be));
            check("rnd_mem_wdata", bus.mem_wdata, e_wdata);
            check("rnd_stall_F", 32'(bus.stall_F), 32'(bus.if_req && !x_idone));
            check("rnd_stall_M", 32'(bus.stall_M), 32'(bus.d_req && !x_ddone));

            // Requesters: hold until done, then either re-request or drop
            if (x_idone) begin
                if ($urandom_range(0, 1) == 1) bus.if_addr = $urandom;
                else                           bus.if_req  = 1'b0;
            end else if (!bus.if_req && $urandom_range(0, 3) == 0) begin
                bus.if_req  = 1'b1;
                bus.if_addr = $urandom;
            end
            if (x_ddone || (!bus.d_req && $urandom_range(0, 2) == 0)) begin
                if (x_ddone && $urandom_range(0, 1) == 0) begin
                    bus.d_req = 1'b0;
                end else begin
                    bus.d_req   = 1'b1;
                    bus.d_we    = 1'($urandom_range(0, 1));
                    bus.d_be    = 4'($urandom);
                    bus.d_addr  = $urandom;
                    bus.d_wdata = $urandom;
                end
            end

            // Arbitration whenever the arbiter is idle at this sample
            if (n >= m_next_idle) begin
                if (!bus.if_req) m_starve = 0;
                if (bus.if_req || bus.d_req) begin
                    m_d = bus.d_req && (!bus.if_req || m_starve < int'(SL));
                    if (m_d) begin
                        if (bus.if_req) m_starve = m_starve + 1;
                        e_addr  = bus.d_addr;
                        e_we    = bus.d_we;
                        e_be    = bus.d_be;
                        e_wdata = bus.d_wdata;
                    end else begin
                        m_starve = 0;
                        e_addr  = bus.if_addr;
                        e_we    = 1'b0;
                        e_be    = 4'hF;
                        e_wdata = 32'h0;
                    end
                    m_r = int'($urandom_range(0, 9));
                    if (m_r < 7)      m_ack_dly = int'($urandom_range(0, 4));
                    else if (m_r < 9) m_ack_dly = int'($urandom_range(5, TO - 1));
                    else              m_ack_dly = int'($urandom_range(TO, TO + 4));
                    m_err       = (m_ack_dly >= int'(TO));
                    m_len       = m_err ? int'(TO) : m_ack_dly + 1;
                    m_g         = n;
                    m_txn       = 1'b1;
                    m_next_idle = n + m_len + 2;
                    m_rd        = $urandom;
                end
            end

            // Memory model: ack on the scheduled BUSY cycle, stray acks elsewhere
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = $urandom;
            if (m_txn && (n >= m_g + 1) && (n <= m_g + m_len)) begin
                if (!m_err && (n == m_g + 1 + m_ack_dly)) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = m_rd;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                bus.mem_ack = 1'b1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
